// File: rtl/experiment_1_if.sv
// Switch/LED/7-segment bundle between the lab top and the switch-status display block.
interface experiment_1_if;
  localparam int unsigned SW_W     = 18;
  localparam int unsigned GREEN_W  = 9;
  localparam int unsigned SEG_W    = 7;
  localparam int unsigned DIGITS   = 8;

  logic [SW_W-1:0]    SWITCH_I;
  logic [SEG_W-1:0]   SEVEN_SEGMENT_N_O [DIGITS];
  logic [SW_W-1:0]    LED_RED_O;
  logic [GREEN_W-1:0] LED_GREEN_O;

  modport master (
    output SWITCH_I,
    input  SEVEN_SEGMENT_N_O,
    input  LED_RED_O,
    input  LED_GREEN_O
  );

  modport slave (
    input  SWITCH_I,
    output SEVEN_SEGMENT_N_O,
    output LED_RED_O,
    output LED_GREEN_O
  );
endinterface

// File: rtl/experiment_1.sv
// Switch-status display: raw switches on red LEDs, summary flags on green LEDs,
// hex value / decimal popcount / parity on eight active-low 7-segment digits.
module experiment_1 (
  input logic           CLOCK_50_I,
  input logic           RESET_I,
  experiment_1_if.slave bus
);
  localparam int unsigned SW_W    = 18;
  localparam int unsigned GREEN_W = 9;
  localparam int unsigned SEG_W   = 7;
  localparam int unsigned DIGITS  = 8;
  localparam int unsigned P_W     = 5;
  localparam int unsigned HEX_DIG = 5;

  localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;

  // Segment font, {g,f,e,d,c,b,a}, 0 = lit
  function automatic logic [SEG_W-1:0] hex_font(input logic [3:0] v);
    logic [SEG_W-1:0] f;
    case (v)
      4'h0: f = 7'h40;  4'h1: f = 7'h79;  4'h2: f = 7'h24;  4'h3: f = 7'h30;
      4'h4: f = 7'h19;  4'h5: f = 7'h12;  4'h6: f = 7'h02;  4'h7: f = 7'h78;
      4'h8: f = 7'h00;  4'h9: f = 7'h10;  4'hA: f = 7'h08;  4'hB: f = 7'h03;
      4'hC: f = 7'h46;  4'hD: f = 7'h21;  4'hE: f = 7'h06;  default: f = 7'h0E;
    endcase
    return f;
  endfunction

  logic [P_W-1:0]     pop;
  logic               parity;
  logic [P_W-1:0]     pop_ones;
  logic               pop_tens;
  logic [SW_W+1:0]    sw_ext;
  logic [GREEN_W-1:0] green_nxt;
  logic [SEG_W-1:0]   seg_nxt [DIGITS];

  // Decode of the incoming switches; everything is captured on the same edge
  always_comb begin
    pop      = '0;
    sw_ext   = {2'b00, bus.SWITCH_I};
    for (int i = 0; i < int'(SW_W); i++) begin
      pop = pop + P_W'(bus.SWITCH_I[i]);
    end
    parity   = ^bus.SWITCH_I;
    pop_tens = (pop >= P_W'(10));
    pop_ones = pop_tens ? pop - P_W'(10) : pop;

    green_nxt = {&bus.SWITCH_I, |bus.SWITCH_I, ~|bus.SWITCH_I, parity, pop};

    for (int d = 0; d < int'(DIGITS); d++) begin
      seg_nxt[d] = SEG_BLANK;
    end
    for (int d = 0; d < int'(HEX_DIG); d++) begin
      seg_nxt[d] = hex_font(sw_ext[4*d +: 4]);
    end
    seg_nxt[5] = hex_font(pop_ones[3:0]);
    seg_nxt[6] = pop_tens ? hex_font(4'h1) : SEG_BLANK;
    seg_nxt[7] = hex_font({3'b000, parity});
  end

  always_ff @(posedge CLOCK_50_I) begin
    if (RESET_I) begin
      bus.LED_RED_O   <= '0;
      bus.LED_GREEN_O <= '0;
      for (int d = 0; d < int'(DIGITS); d++) begin
        bus.SEVEN_SEGMENT_N_O[d] <= SEG_BLANK;
      end
    end else begin
      bus.LED_RED_O   <= bus.SWITCH_I;
      bus.LED_GREEN_O <= green_nxt;
      for (int d = 0; d < int'(DIGITS); d++) begin
        bus.SEVEN_SEGMENT_N_O[d] <= seg_nxt[d];
      end
    end
  end
endmodule

// File: tb/tb_experiment_1.sv
// Bench for experiment_1: directed vector table, reset sequences, and random
// switches checked against a behavioural reference model.
module tb_experiment_1;
  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  experiment_1_if bus ();

  experiment_1 dut (
    .CLOCK_50_I (clk),
    .RESET_I    (rst),
    .bus        (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [17:0]     sw;
    logic [17:0]     red;
    logic [8:0]      green;
    logic [7:0][6:0] seg;
  } vec_t;

  logic [6:0] font [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                            7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  function automatic vec_t reset_vals(input logic [17:0] s);
    vec_t r;
    r.sw    = s;
    r.red   = '0;
    r.green = '0;
    for (int d = 0; d < 8; d++) r.seg[d] = 7'h7F;
    return r;
  endfunction

  // Reference: arithmetic on the popcount, font lookups per digit
  function automatic vec_t model(input logic [17:0] s);
    vec_t r;
    int   p;
    int   nib;
    p        = $countones(s);
    r.sw     = s;
    r.red    = s;
    r.green  = '0;
    r.green[4:0] = 5'(p);
    r.green[5]   = (p % 2) == 1;
    r.green[6]   = (p == 0);
    r.green[7]   = (p > 0);
    r.green[8]   = (p == 18);
    for (int d = 0; d < 5; d++) begin
      nib = (int'(s) >> (4 * d)) % 16;
      r.seg[d] = font[nib];
    end
    r.seg[5] = font[p % 10];
    r.seg[6] = (p < 10) ? 7'h7F : font[p / 10];
    r.seg[7] = font[p % 2];
    return r;
  endfunction

  function automatic logic [7:0][6:0] dut_seg();
    logic [7:0][6:0] s;
    for (int d = 0; d < 8; d++) s[d] = bus.SEVEN_SEGMENT_N_O[d];
    return s;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_all(input string tag, input vec_t e);
    check({tag, " red"},   64'(bus.LED_RED_O),   64'(e.red));
    check({tag, " green"}, 64'(bus.LED_GREEN_O), 64'(e.green));
    check({tag, " seg"},   64'(dut_seg()),       64'(e.seg));
  endtask

  task automatic step(input logic [17:0] s, input logic r);
    @(negedge clk);
    bus.SWITCH_I = s;
    rst          = r;
    @(posedge clk);
    #1;
  endtask

  vec_t vecs [7];

  initial begin
    n_checks = 0;
    n_fail   = 0;

    vecs[0] = '{18'h00001, 18'h00001, 9'b010100001,
                {7'h79, 7'h7F, 7'h79, 7'h40, 7'h40, 7'h40, 7'h40, 7'h79}};
    vecs[1] = '{18'h00003, 18'h00003, 9'b010000010,
                {7'h40, 7'h7F, 7'h24, 7'h40, 7'h40, 7'h40, 7'h40, 7'h30}};
    vecs[2] = '{18'h00007, 18'h00007, 9'b010100011,
                {7'h79, 7'h7F, 7'h30, 7'h40, 7'h40, 7'h40, 7'h40, 7'h78}};
    vecs[3] = '{18'h00009, 18'h00009, 9'b010000010,
                {7'h40, 7'h7F, 7'h24, 7'h40, 7'h40, 7'h40, 7'h40, 7'h10}};
    vecs[4] = '{18'h00011, 18'h00011, 9'b010000010,
                {7'h40, 7'h7F, 7'h24, 7'h40, 7'h40, 7'h40, 7'h79, 7'h79}};
    vecs[5] = '{18'h00000, 18'h00000, 9'b001000000,
                {7'h40, 7'h7F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40}};
    vecs[6] = '{18'h0FEDC, 18'h0FEDC, 9'b010001100,
                {7'h40, 7'h79, 7'h24, 7'h40, 7'h0E, 7'h06, 7'h21, 7'h46}};

    bus.SWITCH_I = 18'h2A5A5;
    rst          = 1'b1;

    // Two reset edges with switches non-zero
    step(18'h2A5A5, 1'b1);
    step(18'h2A5A5, 1'b1);
    check_all("reset", reset_vals(18'h2A5A5));

    // Directed vector table
    for (int i = 0; i < 7; i++) begin
      step(vecs[i].sw, 1'b0);
      check_all($sformatf("vec%0d", i), vecs[i]);
    end

    // All ones, then stability just before the next edge
    step(18'h3FFFF, 1'b0);
    check_all("all_ones", '{18'h3FFFF, 18'h3FFFF, 9'b110010010,
                            {7'h40, 7'h79, 7'h00, 7'h30, 7'h0E, 7'h0E, 7'h0E, 7'h0E}});
    #7;
    check_all("all_ones_stable", model(18'h3FFFF));

    // Mid-operation reset for one edge, then recovery
    step(18'h3FFFF, 1'b1);
    check_all("mid_reset", reset_vals(18'h3FFFF));
    step(18'h3FFFF, 1'b0);
    check_all("post_reset", model(18'h3FFFF));

    // Random switches with occasional reset
    for (int i = 0; i < 300; i++) begin
      logic [17:0] s;
      logic        r;
      s = 18'($urandom);
      if (i % 7 == 3) s = '1;
      if (i % 11 == 5) s = 18'(1) << $urandom_range(0, 17);
      r = ($urandom_range(0, 15) == 0);
      step(s, r);
      check_all($sformatf("rand%0d", i), r ? reset_vals(s) : model(s));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
